// File: rtl/instr_fetch_unit_if.sv
// ROM fetch bus between the nibble ROM, the fetch stage and the decoder.
// slave: inputs are cycle/romData/pcHighIn/jumpCond, outputs are the latched instruction and pc controls.
interface instr_fetch_unit_if;
  logic [2:0]  cycle;
  logic [3:0]  romData;
  logic [3:0]  pcHighIn;
  logic        jumpCond;
  logic [3:0]  opr;
  logic [3:0]  opa;
  logic [7:0]  operand8;
  logic        twoWord;
  logic        secondFrame;
  logic        instrValid;
  logic        pcLoad;
  logic [11:0] pcNew;
  logic        stackPush;

  modport slave (
    input  cycle,
    input  romData,
    input  pcHighIn,
    input  jumpCond,
    output opr,
    output opa,
    output operand8,
    output twoWord,
    output secondFrame,
    output instrValid,
    output pcLoad,
    output pcNew,
    output stackPush
  );

  modport master (
    output cycle,
    output romData,
    output pcHighIn,
    output jumpCond,
    input  opr,
    input  opa,
    input  operand8,
    input  twoWord,
    input  secondFrame,
    input  instrValid,
    input  pcLoad,
    input  pcNew,
    input  stackPush
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch/latch: captures OPR/OPA per frame, assembles two-word ops.
// Ports: clk, rstN (async low), bus (slave: ROM in, latched instr + pc control out).
module instr_fetch_unit #(
  parameter int unsigned M1_CYCLE = 3,
  parameter int unsigned M2_CYCLE = 4
) (
  input  logic               clk,
  input  logic               rstN,
  instr_fetch_unit_if.slave  bus
);

  localparam logic [2:0] LP_M1  = 3'(M1_CYCLE);
  localparam logic [2:0] LP_M2  = 3'(M2_CYCLE);
  localparam logic [2:0] LP_JMP = 3'd6;
  localparam logic [2:0] LP_END = 3'd7;

  typedef enum logic {
    FETCH1 = 1'b0,
    FETCH2 = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [3:0]  r_opr;
  logic [3:0]  r_opa;
  logic [7:0]  r_op8;
  logic        r_two;
  logic        r_valid;
  logic        r_ld;
  logic        r_push;
  logic [11:0] r_pcnew;

  logic        w_m1;
  logic        w_m2;
  logic        w_jmp;
  logic        w_end;
  logic        w_two;
  logic        w_jun;
  logic        w_jms;
  logic        w_cnd;
  logic        w_ld;
  logic        w_push;
  logic [11:0] w_tgt;

  assign w_m1  = (bus.cycle == LP_M1);
  assign w_m2  = (bus.cycle == LP_M2);
  assign w_jmp = (bus.cycle == LP_JMP);
  assign w_end = (bus.cycle == LP_END);

  // OPA is still on the bus at M2, so FIM/SRC split uses romData[0].
  assign w_two = (r_opr == 4'h1) |
                 ((r_opr == 4'h2) & ~bus.romData[0]) |
                 (r_opr == 4'h4) |
                 (r_opr == 4'h5) |
                 (r_opr == 4'h7);

  assign w_jun = (r_opr == 4'h4);
  assign w_jms = (r_opr == 4'h5);
  assign w_cnd = (r_opr == 4'h1) | (r_opr == 4'h7);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) r_state <= FETCH1;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ld        = 1'b0;
    w_push      = 1'b0;
    w_tgt       = r_pcnew;
    unique case (r_state)
      FETCH1: begin
        if (w_end && r_two) w_state_nxt = FETCH2;
      end
      FETCH2: begin
        if (w_end) w_state_nxt = FETCH1;
        if (w_jmp) begin
          unique case (1'b1)
            w_jun: begin
              w_ld  = 1'b1;
              w_tgt = {r_opa, r_op8};
            end
            w_jms: begin
              w_ld   = 1'b1;
              w_push = 1'b1;
              w_tgt  = {r_opa, r_op8};
            end
            w_cnd: begin
              w_ld  = bus.jumpCond;
              w_tgt = {bus.pcHighIn, r_op8};
            end
            default: ;
          endcase
        end
      end
      default: w_state_nxt = FETCH1;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_opr   <= '0;
      r_opa   <= '0;
      r_op8   <= '0;
      r_two   <= 1'b0;
      r_valid <= 1'b0;
      r_ld    <= 1'b0;
      r_push  <= 1'b0;
      r_pcnew <= '0;
    end else begin
      r_valid <= 1'b0;
      r_ld    <= w_ld;
      r_push  <= w_push;
      if (w_ld) r_pcnew <= w_tgt;
      if (r_state == FETCH1) begin
        if (w_m1) r_opr <= bus.romData;
        if (w_m2) begin
          r_opa   <= bus.romData;
          r_op8   <= '0;
          r_two   <= w_two;
          r_valid <= ~w_two;
        end
      end else begin
        if (w_m1) r_op8[7:4] <= bus.romData;
        if (w_m2) begin
          r_op8[3:0] <= bus.romData;
          r_valid    <= 1'b1;
        end
      end
    end
  end

  assign bus.opr         = r_opr;
  assign bus.opa         = r_opa;
  assign bus.operand8    = r_op8;
  assign bus.twoWord     = r_two;
  assign bus.secondFrame = (r_state == FETCH2);
  assign bus.instrValid  = r_valid;
  assign bus.pcLoad      = r_ld;
  assign bus.pcNew       = r_pcnew;
  assign bus.stackPush   = r_push;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a frame-level model.
// Drives cycle/romData per clk, checks every output once per cycle.
module tb_instr_fetch_unit;

  logic clk;
  logic rstN;
  int   n_chk;
  int   n_pass;

  instr_fetch_unit_if bus();

  instr_fetch_unit #(
    .M1_CYCLE(3),
    .M2_CYCLE(4)
  ) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  m_opr;
  logic [3:0]  m_opa;
  logic [7:0]  m_op8;
  bit          m_tw;
  bit          m_sec;
  logic [11:0] m_pcn;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)",
                  tag, obs, exp, $time);
  endtask

  function automatic bit is_two(input logic [7:0] w);
    logic [3:0] hi;
    hi = w[7:4];
    return (hi == 4'h1) || (hi == 4'h4) || (hi == 4'h5) ||
           (hi == 4'h7) || ((hi == 4'h2) && !w[0]);
  endfunction

  task automatic model_reset();
    m_opr = '0;
    m_opa = '0;
    m_op8 = '0;
    m_tw  = 0;
    m_sec = 0;
    m_pcn = '0;
  endtask

  // One 8-cycle frame presenting word w; rst_at<8 asserts reset from that cycle.
  task automatic frame(input logic [7:0] w,
                       input bit jc,
                       input logic [3:0] ph,
                       input int rst_at);
    bit sec;
    bit rsted;
    bit ev;
    bit el;
    bit ep;
    sec   = m_sec;
    rsted = 0;
    for (int c = 0; c < 8; c++) begin
      bus.cycle    = 3'(c);
      bus.romData  = 4'($urandom);
      bus.pcHighIn = 4'($urandom);
      bus.jumpCond = 1'($urandom);
      if (c == 3) bus.romData = w[7:4];
      if (c == 4) bus.romData = w[3:0];
      if (c == 6) begin
        bus.jumpCond = jc;
        bus.pcHighIn = ph;
      end
      if (c == rst_at) begin
        rstN  = 1'b0;
        rsted = 1;
      end
      ev = 0;
      el = 0;
      ep = 0;
      if (rsted) begin
        model_reset();
      end else if (!sec) begin
        if (c == 4) m_opr = w[7:4];
        if (c == 5) begin
          m_opa = w[3:0];
          m_op8 = '0;
          m_tw  = is_two(w);
          ev    = !m_tw;
        end
      end else begin
        if (c == 4) m_op8[7:4] = w[7:4];
        if (c == 5) begin
          m_op8[3:0] = w[3:0];
          ev = 1;
        end
        if (c == 7) begin
          if (m_opr == 4'h4 || m_opr == 4'h5) begin
            el    = 1;
            ep    = (m_opr == 4'h5);
            m_pcn = {m_opa, m_op8};
          end else if ((m_opr == 4'h1 || m_opr == 4'h7) && jc) begin
            el    = 1;
            m_pcn = {ph, m_op8};
          end
        end
      end
      @(negedge clk);
      chk("opr",         32'(bus.opr),         32'(m_opr));
      chk("opa",         32'(bus.opa),         32'(m_opa));
      chk("operand8",    32'(bus.operand8),    32'(m_op8));
      chk("twoWord",     32'(bus.twoWord),     32'(m_tw));
      chk("secondFrame", 32'(bus.secondFrame), 32'(sec && !rsted));
      chk("instrValid",  32'(bus.instrValid),  32'(ev));
      chk("pcLoad",      32'(bus.pcLoad),      32'(el));
      chk("stackPush",   32'(bus.stackPush),   32'(ep));
      chk("pcNew",       32'(bus.pcNew),       32'(m_pcn));
      @(posedge clk);
      #1;
    end
    if (rsted) begin
      rstN  = 1'b1;
      m_sec = 0;
    end else begin
      m_sec = !sec && m_tw;
    end
  endtask

  initial begin
    n_chk        = 0;
    n_pass       = 0;
    rstN         = 1'b0;
    bus.cycle    = 3'd0;
    bus.romData  = 4'h0;
    bus.pcHighIn = 4'h0;
    bus.jumpCond = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_opr",   32'(bus.opr),         32'h0);
    chk("rst_op8",   32'(bus.operand8),    32'h0);
    chk("rst_sec",   32'(bus.secondFrame), 32'h0);
    chk("rst_valid", 32'(bus.instrValid),  32'h0);
    chk("rst_pcnew", 32'(bus.pcNew),       32'h0);
    @(posedge clk);
    #1;
    rstN = 1'b1;

    frame(8'hD5, 1'b0, 4'h0, 8);
    frame(8'h4A, 1'b0, 4'h0, 8);
    frame(8'h5C, 1'b0, 4'h0, 8);
    frame(8'h50, 1'b0, 4'h0, 8);
    frame(8'h07, 1'b0, 4'h0, 8);
    frame(8'h1C, 1'b0, 4'h2, 8);
    frame(8'h34, 1'b1, 4'h2, 8);
    frame(8'h1C, 1'b0, 4'h2, 8);
    frame(8'h34, 1'b0, 4'h2, 8);
    frame(8'h20, 1'b1, 4'h0, 8);
    frame(8'hAB, 1'b1, 4'h0, 8);
    frame(8'h21, 1'b1, 4'h0, 8);
    frame(8'h4A, 1'b0, 4'h0, 8);
    frame(8'h5C, 1'b0, 4'h0, 2);
    frame(8'hD3, 1'b0, 4'h0, 8);

    for (int i = 0; i < 300; i++) begin
      int ra;
      ra = ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 7)) : 8;
      frame(8'($urandom), 1'($urandom), 4'($urandom), ra);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch/latch stage between the ROM nibble output and decoderWithCc. It captures OPR and OPA from the 4-bit ROM bus during the M1 and M2 cycles of each 8-cycle machine frame. It assembles the two-word instructions (JCN, FIM, JUN, JMS, ISZ) over two frames. For the jump forms it generates the pcLoad/pcNew pair and stack push, which replace the constants currently tied to the pc and stack.

Parameters:
- M1_CYCLE, 3, cycle value during which the ROM presents OPR (or the high operand nibble).
- M2_CYCLE, 4, cycle value during which the ROM presents OPA (or the low operand nibble).

Ports:
- clk  input  1  system clock (the toggle clock); cycle advances by exactly one per rising edge, 0..7 wrapping.
- rstN  input  1  asynchronous active-low reset.
- cycle  input  3  frame cycle from clockReset (0=A1 … 7=X3).
- romData  input  4  ROM nibble for the current cycle.
- pcHighIn  input  4  pcHigh, used as the page for JCN/ISZ targets.
- jumpCond  input  1  condition result from the decoder (CC for JCN, register-not-zero for ISZ).
- opr  output  4  latched opcode high nibble.
- opa  output  4  latched opcode low nibble.
- operand8  output  8  second instruction word; {OPR2,OPA2}.
- twoWord  output  1  latched instruction is a two-word type.
- secondFrame  output  1  current frame is fetching word 2; the decoder must not execute.
- instrValid  output  1  one-clk pulse: opr/opa/operand8 complete for the instruction.
- pcLoad  output  1  one-clk pulse: pc loads pcNew.
- pcNew  output  12  jump target.
- stackPush  output  1  one-clk pulse coincident with pcLoad for JMS.

Behaviour:
- Reset (async, rstN=0): every output is 0 and state=FETCH1. Reset asserted mid-instruction discards a partial two-word fetch. After release, the first captured OPR is at the next cycle==M1_CYCLE edge.
- All captures are registered at rising clk edges. A value captured at the edge where cycle==N is visible while cycle==N+1.
- State FETCH1:
  - At the edge with cycle==M1: opr←romData.
  - At the edge with cycle==M2: opa←romData, operand8←0, twoWord←decode(opr, romData).
  - Two-word decode: opr=1 (JCN); opr=2 with OPA[0]=0 (FIM); opr=4 (JUN); opr=5 (JMS); opr=7 (ISZ). Opr=2 with OPA[0]=1 (SRC) is single-word.
  - Single-word instruction: instrValid=1 during cycle 5 of the same frame; stay in FETCH1.
  - Two-word instruction: at the edge with cycle==7, go to FETCH2; secondFrame=1 for the whole next frame (cycle 0..7). instrValid stays 0.
- State FETCH2:
  - opr/opa/twoWord hold.
  - Edge cycle==M1: operand8[7:4]←romData.
  - Edge cycle==M2: operand8[3:0]←romData; instrValid=1 during cycle 5.
  - Edge cycle==6 (pcLoad/pcNew/stackPush visible during cycle 7 only):
    - JUN: pcLoad=1, pcNew={opa, operand8}.
    - JMS: same as JUN, plus stackPush=1.
    - JCN/ISZ: jumpCond sampled; if 1, pcLoad=1, pcNew={pcHighIn, operand8}; if 0, no pulse.
    - FIM: no pcLoad.
  - Edge cycle==7: secondFrame←0, state←FETCH1.
- pcNew holds its last value when pcLoad=0. It is 0 after reset.
- instrValid, pcLoad and stackPush are never high for more than one clk per frame.
- romData is ignored on every cycle other than M1/M2.
- jumpCond is ignored outside cycle 6 of a FETCH2 frame.

Test Plan:
- Reset, ROM frames 0xD5 (LDM 5) -> opr=D, opa=5, twoWord=0, instrValid high only in cycle 5, no pcLoad, secondFrame=0.
- Frames 0x4A, 0x5C (JUN) -> secondFrame=1 across frame 2; instrValid in frame 2 cycle 5 with operand8=0x5C; pcLoad=1, pcNew=0xA5C in frame 2 cycle 7; stackPush=0.
- Frames 0x50, 0x07 (JMS) -> pcLoad=1 and stackPush=1 together in cycle 7, pcNew=0x007.
- Frames 0x1C, 0x34 (JCN), pcHighIn=2:
  - jumpCond=1 at cycle 6 -> pcNew=0x234, pcLoad pulse.
  - Repeat with jumpCond=0 -> no pcLoad, pcNew unchanged.
- Frames 0x20, 0xAB (FIM), then 0x21 (SRC):
  - FIM: twoWord=1, operand8=0xAB, no pcLoad.
  - SRC: single-word, instrValid in its own frame cycle 5, operand8=0.
- JUN first word 0x4A, rstN pulsed low during frame 2 cycle 2 -> all outputs 0 immediately, no pcLoad. Next frame 0xD3 decodes as single-word LDM 3.
